// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It scans the digits with per-slot blanking, shadows each frame's codes and blinks selected digits.
module seg7_scan_driver #(
  parameter int DIGIT_PERIOD = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] seg_data,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] BLANK_N   = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic [BW-1:0]   blink_cnt_reg, blink_cnt_next;
  logic            phase_on_reg, phase_on_next;
  logic [19:0]     shadow_reg;
  logic [3:0]      an_reg, an_next;
  logic [6:0]      seg_reg, seg_next;
  logic [6:0]      glyph [4];

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h3F;
      5'd15:   s = 7'h41;
      5'd16:   s = 7'h0C;
      5'd17:   s = 7'h23;
      5'd19:   s = 7'h21;
      5'd20:   s = 7'h2B;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
      assign glyph[gi] = decode(shadow_reg[gi*5 +: 5]);
    end
  endgenerate

  // Scan and blink counters run independently of each other.
  always_comb begin
    cnt_next       = cnt_reg + 1'b1;
    idx_next       = idx_reg;
    blink_cnt_next = blink_cnt_reg + 1'b1;
    phase_on_next  = phase_on_reg;
    if (cnt_reg == CNT_MAX) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end
    if (blink_cnt_reg == BLINK_MAX) begin
      blink_cnt_next = '0;
      phase_on_next  = ~phase_on_reg;
    end
  end

  // Next-state logic: the state register tracks cnt_reg one-for-one.
  always_comb begin
    state_next = (cnt_next < BLANK_N) ? BLANK : DRIVE;
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    if (state_reg == DRIVE) begin
      an_next[idx_reg] = 1'b0;
      if (phase_on_reg || !blink_mask[idx_reg]) begin
        seg_next = glyph[idx_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= BLANK;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      blink_cnt_reg <= '0;
      phase_on_reg  <= 1'b1;
      shadow_reg    <= {4{5'd31}};
      an_reg        <= 4'b1111;
      seg_reg       <= 7'h7F;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_on_reg  <= phase_on_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      // Frame start: latch all four codes at once so a frame never tears.
      if (cnt_reg == '0 && idx_reg == 2'd0) begin
        shadow_reg <= seg_data;
      end
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random traffic,
// every cycle compared against a cycle-count-based reference model.
module tb_seg7_scan_driver;
  localparam int DP = 8;
  localparam int BC = 2;
  localparam int BH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] seg_data = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;
  int k = -1;                          // index of latest released edge, -1 while in reset
  logic [19:0] frame_sd = {4{5'd31}};  // codes latched at the latest frame start
  logic [6:0]  lut [32];

  seg7_scan_driver #(
    .DIGIT_PERIOD(DP),
    .BLANK_CYCLES(BC),
    .BLINK_HALF  (BH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_data  (seg_data),
    .blink_mask(blink_mask),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic [19:0] sd;
    logic [3:0]  bm;
    logic        rs;
    int          c;
    int          i;
    @(posedge clk);
    rs = reset;
    sd = seg_data;
    bm = blink_mask;
    e_an  = 4'b1111;
    e_seg = 7'h7F;
    if (!rs) begin
      k = -1;
    end else begin
      k++;
      if (k % (4 * DP) == 0) frame_sd = sd;
      c = k % DP;
      i = (k / DP) % 4;
      if (c >= BC) begin
        e_an  = ~(4'b0001 << i);
        e_seg = (((k / BH) % 2) == 1 && bm[i]) ? 7'h7F : lut[frame_sd[i*5 +: 5]];
      end
    end
    #1;
    tests++;
    assert (an === e_an) else begin
      fails++;
      $error("FAIL an k=%0d got %b exp %b", k, an, e_an);
    end
    tests++;
    assert (seg === e_seg) else begin
      fails++;
      $error("FAIL seg k=%0d got %h exp %h", k, seg, e_seg);
    end
    tests++;
    assert (dp === 1'b1) else begin
      fails++;
      $error("FAIL dp k=%0d got %b exp 1", k, dp);
    end
    tests++;
    assert ($countones(~an) <= 1) else begin
      fails++;
      $error("FAIL onehot k=%0d got %b exp at most one zero", k, an);
    end
  endtask

  initial begin
    foreach (lut[j]) lut[j] = 7'h7F;
    lut[0]  = 7'h40; lut[1]  = 7'h79; lut[2]  = 7'h24; lut[3]  = 7'h30;
    lut[4]  = 7'h19; lut[5]  = 7'h12; lut[6]  = 7'h02; lut[7]  = 7'h78;
    lut[8]  = 7'h00; lut[9]  = 7'h10; lut[10] = 7'h3F; lut[15] = 7'h41;
    lut[16] = 7'h0C; lut[17] = 7'h23; lut[19] = 7'h21; lut[20] = 7'h2B;

    // reset held low with arbitrary data
    reset = 1'b0;
    seg_data = 20'($urandom);
    repeat (5) tick();

    // scan order
    seg_data = {5'd1, 5'd2, 5'd10, 5'd31};
    reset = 1'b1;
    repeat (64) tick();

    // glyphs: "good", then U P n and an undefined code
    reset = 1'b0;
    tick();
    seg_data = {5'd9, 5'd17, 5'd17, 5'd19};
    reset = 1'b1;
    repeat (32) tick();
    seg_data = {5'd15, 5'd16, 5'd20, 5'd12};
    repeat (32) tick();

    // no tearing: change codes at frame cycle 13
    reset = 1'b0;
    tick();
    seg_data = {5'd3, 5'd4, 5'd5, 5'd6};
    reset = 1'b1;
    repeat (14) tick();
    seg_data = {5'd7, 5'd0, 5'd8, 5'd9};
    repeat (50) tick();

    // blink on digit 0 with all digits '8'
    reset = 1'b0;
    tick();
    seg_data = {4{5'd8}};
    blink_mask = 4'b0001;
    reset = 1'b1;
    repeat (160) tick();

    // reset pulse landing on a DRIVE cycle of digit 2
    while (k % (4 * DP) != 19) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (40) tick();

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) seg_data = 20'($urandom);
      if ($urandom_range(31) == 0) blink_mask = 4'($urandom);
      reset = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
